// File: rtl/induct_stop_ctrl.sv
// Inductive marker stop controller: synchronises and debounces two metal sensors,
// latches a motor stop on a confirmed hit and holds off re-detection after resume.
module induct_stop_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned HOLDOFF_CYCLES  = 100000000,
    parameter int unsigned CNT_W           = 27,
    parameter int unsigned HOME_STATE_A    = 12,
    parameter int unsigned HOME_STATE_B    = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       InductA,
    input  logic       InductB,
    input  logic       arm,
    input  logic       resume,
    input  logic [3:0] freq_state,
    output logic       on_induct,
    output logic       ind_event,
    output logic       motor_stop,
    output logic       home_flag,
    output logic [1:0] ctrl_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        STOPPED = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    function automatic logic is_home(input logic [3:0] fs);
        return (fs == 4'(HOME_STATE_A)) || (fs == 4'(HOME_STATE_B));
    endfunction

    logic [1:0]       sync_a_r;
    logic [1:0]       sync_b_r;
    logic             raw_metal_s;
    logic             filt_metal_r;
    logic [CNT_W-1:0] deb_cnt_r;
    logic [CNT_W-1:0] hold_cnt_r;
    logic             on_induct_r;
    logic             ind_event_r;
    logic             motor_stop_r;
    logic             home_flag_r;
    state_t           state_r;

    // Two-flop synchronisers; idle high means no metal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a_r <= 2'b11;
            sync_b_r <= 2'b11;
        end else begin
            sync_a_r <= {sync_a_r[0], InductA};
            sync_b_r <= {sync_b_r[0], InductB};
        end
    end

    assign raw_metal_s = ~(sync_a_r[1] & sync_b_r[1]);

    // Debounce filter: the counter only runs while raw and filtered disagree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_cnt_r    <= '0;
            filt_metal_r <= 1'b0;
            on_induct_r  <= 1'b1;
        end else begin
            on_induct_r <= ~filt_metal_r;
            if (raw_metal_s == filt_metal_r) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r == DEB_LAST) begin
                filt_metal_r <= raw_metal_s;
                deb_cnt_r    <= '0;
            end else begin
                deb_cnt_r <= deb_cnt_r + CNT_W'(1);
            end
        end
    end

    // Control FSM with registered outputs; dropping arm always wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            hold_cnt_r   <= '0;
            ind_event_r  <= 1'b0;
            motor_stop_r <= 1'b0;
            home_flag_r  <= 1'b0;
        end else begin
            ind_event_r <= 1'b0;
            if (!arm) begin
                home_flag_r <= 1'b0;
            end else if ((state_r == ARMED) && filt_metal_r && is_home(freq_state)) begin
                home_flag_r <= 1'b1;
            end else begin
                home_flag_r <= home_flag_r;
            end

            case (state_r)
                IDLE: begin
                    motor_stop_r <= 1'b0;
                    state_r      <= arm ? ARMED : IDLE;
                end
                ARMED: begin
                    if (!arm) begin
                        state_r      <= IDLE;
                        motor_stop_r <= 1'b0;
                    end else if (filt_metal_r) begin
                        state_r      <= STOPPED;
                        ind_event_r  <= 1'b1;
                        motor_stop_r <= 1'b1;
                    end else begin
                        motor_stop_r <= 1'b0;
                    end
                end
                STOPPED: begin
                    if (!arm) begin
                        state_r      <= IDLE;
                        motor_stop_r <= 1'b0;
                    end else if (resume) begin
                        state_r      <= HOLDOFF;
                        hold_cnt_r   <= '0;
                        motor_stop_r <= 1'b0;
                    end else begin
                        motor_stop_r <= 1'b1;
                    end
                end
                HOLDOFF: begin
                    motor_stop_r <= 1'b0;
                    if (!arm) begin
                        state_r    <= IDLE;
                        hold_cnt_r <= '0;
                    end else if (hold_cnt_r == HOLD_LAST) begin
                        state_r    <= ARMED;
                        hold_cnt_r <= '0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    hold_cnt_r   <= '0;
                    motor_stop_r <= 1'b0;
                end
            endcase
        end
    end

    assign on_induct  = on_induct_r;
    assign ind_event  = ind_event_r;
    assign motor_stop = motor_stop_r;
    assign home_flag  = home_flag_r;
    assign ctrl_state = state_r;

endmodule

// File: tb/tb_induct_stop_ctrl.sv
// Directed, table-driven bench for induct_stop_ctrl with DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=10.
module tb_induct_stop_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       InductA, InductB, arm, resume;
    logic [3:0] freq_state;
    logic       on_induct, ind_event, motor_stop, home_flag;
    logic [1:0] ctrl_state;

    int checks = 0;
    int errors = 0;

    induct_stop_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .HOLDOFF_CYCLES (10),
        .CNT_W          (27),
        .HOME_STATE_A   (12),
        .HOME_STATE_B   (13)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .InductA   (InductA),
        .InductB   (InductB),
        .arm       (arm),
        .resume    (resume),
        .freq_state(freq_state),
        .on_induct (on_induct),
        .ind_event (ind_event),
        .motor_stop(motor_stop),
        .home_flag (home_flag),
        .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       arm;
        logic       a;
        logic       b;
        logic       res;
        logic [3:0] fs;
        logic       ms;
        logic       ev;
        logic [1:0] st;
        logic       on;
        logic       home;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic a_arm, input logic a_a, input logic a_b, input logic a_res,
                       input logic [3:0] a_fs, input logic e_ms, input logic e_ev,
                       input logic [1:0] e_st, input logic e_on, input logic e_home);
        vec_t v;
        v.arm = a_arm; v.a = a_a; v.b = a_b; v.res = a_res; v.fs = a_fs;
        v.ms = e_ms; v.ev = e_ev; v.st = e_st; v.on = e_on; v.home = e_home;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_ms, input logic e_ev,
                             input logic [1:0] e_st, input logic e_on, input logic e_home);
        check({tag, ".motor_stop"}, {1'b0, motor_stop}, {1'b0, e_ms});
        check({tag, ".ind_event"},  {1'b0, ind_event},  {1'b0, e_ev});
        check({tag, ".ctrl_state"}, ctrl_state,         e_st);
        check({tag, ".on_induct"},  {1'b0, on_induct},  {1'b0, e_on});
        check({tag, ".home_flag"},  {1'b0, home_flag},  {1'b0, e_home});
    endtask

    initial begin
        reset = 1'b0; InductA = 1'b1; InductB = 1'b1;
        arm = 1'b0; resume = 1'b0; freq_state = 4'd5;

        // v0: sensor A low and arm from edge 1; filter flips at edge 6, stop at edge 7
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) add(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        // resume pulse: ten cycles of HOLDOFF with metal ignored
        add(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        for (int i = 9; i <= 17; i++) add(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
        // re-detection in a home state sets the sticky flag
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'd12, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
        // resume and arm drop together: IDLE wins, flag clears; sensor released
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 21; i <= 25; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        // 3-cycle glitch on B must not pass the filter; stray resume ignored
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);

        #12;
        check_all("reset", 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            arm = vecs[i].arm; InductA = vecs[i].a; InductB = vecs[i].b;
            resume = vecs[i].res; freq_state = vecs[i].fs;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].ms, vecs[i].ev, vecs[i].st,
                      vecs[i].on, vecs[i].home);
        end

        // Stop again, resume, then reset asynchronously five cycles into HOLDOFF
        InductA = 1'b0; resume = 1'b0; arm = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check_all("stop2", 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        resume = 1'b1;
        @(posedge clk);
        #1;
        resume = 1'b0;
        check_all("hold_entry", 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check({"hold5", ".ctrl_state"}, ctrl_state, 2'd3);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        // metal still present: full sync + debounce again before the new stop
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("post_rst%0d", e), 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        end
        @(posedge clk);
        #1;
        check_all("post_rst7", 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
